dataproc_ctrl: RTL and testbench
================================

Name: dataproc_ctrl

Overview:
Memory-mapped sequencer for the SoC's streaming data processor. The CPU programs the mode and word count over the iomem bus, then starts a job. The block gates the producer stream into the processor, counts issued and returned words, buffers results in a small FIFO the CPU pops, and raises done/irq. It sits between the picosoc iomem decode, the input producer and the dataproc core.

Parameters:
- DATA_W, 32, width of stream and result words.
- LEN_W, 16, width of the job length and counters.
- FIFO_DEPTH, 8, result FIFO depth; power of two, ≥2.
- TIMEOUT_CYCLES, 4096, stall limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous active-low reset.
- reg_valid  in  1  bus request.
- reg_ready  out  1  bus acknowledge, one-cycle pulse.
- reg_wstrb  in  4  byte strobes; 0 means read.
- reg_addr  in  8  byte offset, word aligned.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, valid with reg_ready.
- in_valid / in_ready  in / out  1 each  producer handshake.
- in_data  in  DATA_W  producer word.
- proc_valid / proc_ready  out / in  1 each  processor input handshake.
- proc_data  out  DATA_W  equals in_data.
- proc_mode  out  2  latched mode, stable for the whole job.
- res_valid / res_ready  in / out  1 each  processor output handshake.
- res_data  in  DATA_W  processor result.
- irq  out  1  level interrupt, = done & irq_en.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - State IDLE; all counters, registers and the FIFO cleared.
  - reg_ready=0, reg_rdata=0, in_ready=0, proc_valid=0, res_ready=0, irq=0, proc_mode=0.
- Bus timing:
  - reg_ready goes high the cycle after reg_valid is seen while reg_ready=0.
  - It stays high for exactly one cycle. Writes and reads take effect on that edge.
- Registers:
  - 0x00 CTRL: bit0 START (write-1, self-clearing), bit1 ABORT (write-1), bits3:2 MODE, bit4 IRQ_EN.
  - 0x04 LEN: LEN_W bits; writes are ignored while busy.
  - 0x08 STATUS:
    - bit0 BUSY, bit1 DONE (W1C), bit2 FIFO_EMPTY, bit3 FIFO_FULL, bit4 ABORTED (W1C), bit5 TIMEOUT (W1C, feature only).
    - bits 8+LEN_W-1:8 REMAINING = LEN − returned.
  - 0x0C RESULT: a read pops the FIFO head. Reading while empty returns 0 and does not pop.
  - 0x10 COUNT: results returned in the current or last job.
  - Unmapped addresses: reads return 0, writes are ignored, reg_ready is still given.
- FSM IDLE/RUN/DRAIN:
  - IDLE → RUN on START with LEN≠0. This clears issued, returned, DONE and ABORTED, and latches MODE.
  - START with LEN=0 sets DONE immediately and stays in IDLE.
  - START while busy is ignored.
  - RUN: proc_valid = in_valid, in_ready = proc_ready (combinational pass-through). issued++ on each handshake. Go to DRAIN when issued reaches LEN.
  - DRAIN: in_ready=0, proc_valid=0. Go to IDLE and set DONE when returned reaches LEN.
  - res_ready = (state≠IDLE) & !fifo_full. Each res handshake pushes to the FIFO and increments returned.
  - A res handshake in the same cycle as the final issue is counted normally.
- FIFO boundaries:
  - Full stalls the processor output; nothing is ever dropped.
  - A simultaneous pop and push when full is allowed.
  - A pop and push when empty makes the FIFO non-empty; there is no bypass.
- ABORT in RUN/DRAIN:
  - Next state IDLE, ABORTED=1, DONE unchanged.
  - FIFO contents are kept.
  - In-flight processor results arriving after the abort are discarded (res_ready=0 in IDLE).
- Counters do not wrap within a job, since LEN bounds them.

Optional Feature:
- Macro: DATAPROC_CTRL_TIMEOUT_EN.
- When defined:
  - A stall counter runs in RUN/DRAIN and resets on any proc or res handshake.
  - On reaching TIMEOUT_CYCLES it forces an abort and sets TIMEOUT=1 and ABORTED=1.
  - irq also fires on TIMEOUT when IRQ_EN=1.
- When undefined: no counter, STATUS bit5 reads 0, and the TIMEOUT_CYCLES parameter is unused.

Decomposition:
- Package dataproc_ctrl_pkg holds:
  - register offsets (ADDR_CTRL, ADDR_LEN, ADDR_STATUS, ADDR_RESULT, ADDR_COUNT);
  - state encoding (ST_IDLE, ST_RUN, ST_DRAIN);
  - STATUS/CTRL bit indices;
  - MODE encodings.
- One sub-module, dataproc_res_fifo: a synchronous FIFO with push, pop, full, empty and data out.

Test Plan:
- Reset, then read STATUS → 0x00000004 (FIFO_EMPTY only); irq=0; in_ready=0.
- LEN=4, MODE=2, START, producer streams 4 words, processor echoes each +1 → proc_mode=2 throughout, DONE=1, COUNT=4, 4 RESULT reads return inputs+1, then EMPTY=1.
- FIFO_DEPTH=8, LEN=12, CPU reads no results → res_ready drops after 8 pushes, BUSY stays 1. After 4 pops the job completes with DONE=1 and nothing lost.
- START with LEN=0 and IRQ_EN=1 → DONE=1 and irq=1 on the cycle after reg_ready, BUSY never 1. Writing 0x2 to STATUS clears irq.
- LEN=10, ABORT after 3 issues → state IDLE, ABORTED=1, DONE=0, in_ready=0. A later res_valid sees res_ready=0.
- With DATAPROC_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=16, LEN=2 and processor silent → TIMEOUT=1 and ABORTED=1 at cycle 16 after the last handshake.

Source files
------------

// File: rtl/dataproc_ctrl_pkg.sv
// Shared definitions for the dataproc sequencer: register map, FSM states,
// STATUS/CTRL bit positions and processor mode encodings.
package dataproc_ctrl_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_LEN    = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;
  localparam logic [7:0] ADDR_RESULT = 8'h0C;
  localparam logic [7:0] ADDR_COUNT  = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_MODE_LO = 2;
  localparam int unsigned CTRL_MODE_HI = 3;
  localparam int unsigned CTRL_IRQ_EN  = 4;

  localparam int unsigned STAT_BUSY       = 0;
  localparam int unsigned STAT_DONE       = 1;
  localparam int unsigned STAT_FIFO_EMPTY = 2;
  localparam int unsigned STAT_FIFO_FULL  = 3;
  localparam int unsigned STAT_ABORTED    = 4;
  localparam int unsigned STAT_TIMEOUT    = 5;
  localparam int unsigned STAT_REM_LSB    = 8;

  typedef enum logic [1:0] {
    MODE_0 = 2'd0,
    MODE_1 = 2'd1,
    MODE_2 = 2'd2,
    MODE_3 = 2'd3
  } mode_t;

endpackage

// File: rtl/dataproc_res_fifo.sv
// Synchronous result FIFO; a push while full is accepted only when a pop
// frees the head slot on the same edge. No read-through bypass.
module dataproc_res_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dataproc_ctrl.sv
// Memory-mapped job sequencer for the streaming dataproc core.
// Optional stall watchdog: define DATAPROC_CTRL_TIMEOUT_EN.
module dataproc_ctrl
  import dataproc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned LEN_W          = 16,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              reg_valid,
  output logic              reg_ready,
  input  logic [3:0]        reg_wstrb,
  input  logic [7:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              proc_valid,
  input  logic              proc_ready,
  output logic [DATA_W-1:0] proc_data,
  output logic [1:0]        proc_mode,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  output logic              irq
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t            state_q;
  state_t            state_d;
  logic              reg_ready_q;
  logic [31:0]       reg_rdata_q;
  logic [31:0]       read_val;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  returned_q;
  logic [LEN_W-1:0]  issued_nxt;
  logic [LEN_W-1:0]  returned_nxt;
  logic [LEN_W-1:0]  remaining;
  mode_t             ctrl_mode_q;
  mode_t             run_mode_q;
  logic              irq_en_q;
  logic              done_q;
  logic              aborted_q;
  logic              timeout_q;
  logic              timeout_hit;

  logic              acc;
  logic              wr;
  logic              rd;
  logic              wr_ctrl;
  logic              wr_len;
  logic              wr_status;
  logic              busy;
  logic              start_req;
  logic              start_ok;
  logic              go;
  logic              start_zero;
  logic              abort;
  logic              issue;
  logic              push;
  logic              done_evt;
  logic              in_ready_c;
  logic              proc_valid_c;
  logic              res_ready_c;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              unused_wdata;

  assign unused_wdata = ^reg_wdata;

  // Bus decode: one access per reg_valid, acknowledged on the following cycle.
  assign acc       = reg_valid && !reg_ready_q;
  assign wr        = acc && (reg_wstrb != 4'b0000);
  assign rd        = acc && (reg_wstrb == 4'b0000);
  assign wr_ctrl   = wr && (reg_addr == ADDR_CTRL);
  assign wr_len    = wr && (reg_addr == ADDR_LEN);
  assign wr_status = wr && (reg_addr == ADDR_STATUS);
  assign fifo_pop  = rd && (reg_addr == ADDR_RESULT) && !fifo_empty;

  assign busy       = (state_q != ST_IDLE);
  assign start_req  = wr_ctrl && reg_wdata[CTRL_START];
  assign start_ok   = start_req && !busy;
  assign go         = start_ok && (len_q != '0);
  assign start_zero = start_ok && (len_q == '0);
  assign abort      = busy && ((wr_ctrl && reg_wdata[CTRL_ABORT]) || timeout_hit);

  assign issue        = (state_q == ST_RUN) && in_valid && proc_ready;
  assign push         = res_valid && res_ready_c;
  assign issued_nxt   = issued_q + LEN_ONE;
  assign returned_nxt = returned_q + LEN_ONE;
  assign remaining    = len_q - returned_q;
  // Abort takes priority: a completing return in the abort cycle leaves DONE alone.
  assign done_evt     = busy && push && (returned_nxt == len_q) && !abort;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort || done_evt)                 state_d = ST_IDLE;
        else if (issue && issued_nxt == len_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort || done_evt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_c   = 1'b0;
    proc_valid_c = 1'b0;
    res_ready_c  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        in_ready_c   = proc_ready;
        proc_valid_c = in_valid;
        res_ready_c  = !fifo_full;
      end
      ST_DRAIN: begin
        res_ready_c  = !fifo_full;
      end
      default: ;
    endcase
  end

  assign in_ready   = in_ready_c;
  assign proc_valid = proc_valid_c;
  assign res_ready  = res_ready_c;
  assign proc_data  = in_data;
  assign proc_mode  = run_mode_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      len_q       <= '0;
      ctrl_mode_q <= MODE_0;
      run_mode_q  <= MODE_0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      issued_q    <= '0;
      returned_q  <= '0;
    end else begin
      if (wr_len && !busy) len_q <= reg_wdata[LEN_W-1:0];
      if (wr_ctrl) begin
        ctrl_mode_q <= mode_t'(reg_wdata[CTRL_MODE_HI:CTRL_MODE_LO]);
        irq_en_q    <= reg_wdata[CTRL_IRQ_EN];
      end
      if (go) run_mode_q <= mode_t'(reg_wdata[CTRL_MODE_HI:CTRL_MODE_LO]);

      if (start_ok) begin
        issued_q   <= '0;
        returned_q <= '0;
      end else begin
        if (issue) issued_q   <= issued_nxt;
        if (push)  returned_q <= returned_nxt;
      end

      if (done_evt || start_zero)                         done_q <= 1'b1;
      else if (go || (wr_status && reg_wdata[STAT_DONE])) done_q <= 1'b0;

      if (abort)                                             aborted_q <= 1'b1;
      else if (go || (wr_status && reg_wdata[STAT_ABORTED])) aborted_q <= 1'b0;
    end
  end

`ifdef DATAPROC_CTRL_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

  logic [STALL_W-1:0] stall_q;

  // Counts idle cycles since the last proc or res handshake of the job.
  assign timeout_hit = busy && !(issue || push) && (stall_q == STALL_LAST);

  always_ff @(posedge clk) begin
    if (!resetn || !busy || issue || push) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_q + STALL_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end else if (go || (wr_status && reg_wdata[STAT_TIMEOUT])) begin
      timeout_q <= 1'b0;
    end
  end

  assign irq = irq_en_q && (done_q || timeout_q);
`else
  localparam int unsigned UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
  assign irq         = irq_en_q && done_q;
`endif

  always_comb begin
    read_val = '0;
    case (reg_addr)
      ADDR_CTRL: begin
        read_val[CTRL_MODE_HI:CTRL_MODE_LO] = ctrl_mode_q;
        read_val[CTRL_IRQ_EN]               = irq_en_q;
      end
      ADDR_LEN:    read_val[LEN_W-1:0] = len_q;
      ADDR_STATUS: begin
        read_val[STAT_BUSY]             = busy;
        read_val[STAT_DONE]             = done_q;
        read_val[STAT_FIFO_EMPTY]       = fifo_empty;
        read_val[STAT_FIFO_FULL]        = fifo_full;
        read_val[STAT_ABORTED]          = aborted_q;
        read_val[STAT_TIMEOUT]          = timeout_q;
        read_val[STAT_REM_LSB +: LEN_W] = remaining;
      end
      ADDR_RESULT: if (!fifo_empty) read_val[DATA_W-1:0] = fifo_head;
      ADDR_COUNT:  read_val[LEN_W-1:0] = returned_q;
      default:     read_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      reg_ready_q <= 1'b0;
      reg_rdata_q <= '0;
    end else begin
      reg_ready_q <= acc;
      reg_rdata_q <= rd ? read_val : '0;
    end
  end

  assign reg_ready = reg_ready_q;
  assign reg_rdata = reg_rdata_q;

  dataproc_res_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (res_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_dataproc_ctrl.sv
// Scoreboard bench for dataproc_ctrl: register reads are checked by a monitor
// against a queue of expected values; producer and processor are bench models.
module tb_dataproc_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        reg_valid;
  logic        reg_ready;
  logic [3:0]  reg_wstrb;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        proc_valid;
  logic        proc_ready;
  logic [31:0] proc_data;
  logic [1:0]  proc_mode;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        irq;

  always #5 clk = ~clk;

  dataproc_ctrl #(
    .DATA_W         (32),
    .LEN_W          (16),
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .reg_valid  (reg_valid),
    .reg_ready  (reg_ready),
    .reg_wstrb  (reg_wstrb),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .proc_valid (proc_valid),
    .proc_ready (proc_ready),
    .proc_data  (proc_data),
    .proc_mode  (proc_mode),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .irq        (irq)
  );

  typedef struct {
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] prod_q[$];
  logic [31:0] proc_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        proc_en = 1'b1;
  logic [1:0]  exp_mode = 2'd0;
  logic        was_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic bus(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    reg_valid = 1'b1; reg_addr = a; reg_wstrb = s; reg_wdata = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!reg_ready && n < 20);
    if (!reg_ready) begin
      checks++; errors++;
      $display("FAIL bus_ack_timeout: addr 0x%02h got no reg_ready, required within 20 cycles", a);
    end
    @(posedge clk); #1;
    reg_valid = 1'b0; reg_wstrb = 4'h0; reg_wdata = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus(a, 4'hF, d);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    exp_q.push_back('{val: exp, tag: tag});
    bus(a, 4'h0, '0);
  endtask

  // Producer and echo-plus-one processor: sample handshakes mid-cycle, update after the edge.
  initial begin
    logic p_fire, q_fire, r_fire;
    logic [31:0] pd, dummy;
    in_valid = 1'b0; in_data = '0; res_valid = 1'b0; res_data = '0;
    forever begin
      @(negedge clk);
      p_fire = in_valid && in_ready;
      q_fire = proc_valid && proc_ready;
      r_fire = res_valid && res_ready;
      pd     = proc_data;
      @(posedge clk); #1;
      if (r_fire && proc_q.size() != 0) dummy = proc_q.pop_front();
      if (q_fire) proc_q.push_back(pd + 32'd1);
      if (p_fire && prod_q.size() != 0) dummy = prod_q.pop_front();
      in_valid  = (prod_q.size() != 0);
      in_data   = (prod_q.size() != 0) ? prod_q[0] : '0;
      res_valid = proc_en && (proc_q.size() != 0);
      res_data  = (proc_q.size() != 0) ? proc_q[0] : '0;
    end
  end

  // Monitor: read responses against the scoreboard, plus per-issue stream checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && reg_ready) begin
        check("reg_ready_one_cycle", {31'd0, was_ready}, 32'd0);
        if (reg_wstrb == 4'h0) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL read_unexpected: got 0x%08h, required no response", reg_rdata);
          end else begin
            e = exp_q.pop_front();
            check(e.tag, reg_rdata, e.val);
          end
        end
      end
      was_ready = reg_ready;
      if (resetn && proc_valid && proc_ready) begin
        check("proc_mode", {30'd0, proc_mode}, {30'd0, exp_mode});
        check("proc_data", proc_data, (prod_q.size() != 0) ? prod_q[0] : 32'hDEAD_BEEF);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; reg_valid = 1'b0; reg_wstrb = 4'h0; reg_addr = '0; reg_wdata = '0;
    proc_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_reg_ready",  {31'd0, reg_ready},  32'd0);
    check("rst_reg_rdata",  reg_rdata,           32'd0);
    check("rst_in_ready",   {31'd0, in_ready},   32'd0);
    check("rst_proc_valid", {31'd0, proc_valid}, 32'd0);
    check("rst_res_ready",  {31'd0, res_ready},  32'd0);
    check("rst_irq",        {31'd0, irq},        32'd0);
    check("rst_proc_mode",  {30'd0, proc_mode},  32'd0);
    rd(8'h08, 32'h0000_0004, "rst_status");
    rd(8'h40, 32'h0000_0000, "unmapped_read");

    // Basic job: 4 words, mode 2, processor returns word+1.
    proc_en = 1'b1; exp_mode = 2'd2;
    for (int i = 0; i < 4; i++) prod_q.push_back(32'h10 * (i + 1));
    wr(8'h04, 32'd4);
    wr(8'h00, 32'h0000_0009);
    repeat (20) @(posedge clk);
    rd(8'h08, 32'h0000_0002, "job4_status_done");
    rd(8'h10, 32'd4, "job4_count");
    for (int i = 0; i < 4; i++) rd(8'h0C, 32'h10 * (i + 1) + 1, "job4_result");
    rd(8'h08, 32'h0000_0006, "job4_status_empty");
    rd(8'h0C, 32'h0000_0000, "result_empty_read");
    wr(8'h08, 32'h0000_0002);

    // FIFO backpressure: 12 results into an 8-deep FIFO with no CPU reads.
    exp_mode = 2'd1;
    for (int i = 1; i <= 12; i++) prod_q.push_back(i);
    wr(8'h04, 32'd12);
    wr(8'h00, 32'h0000_0005);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("full_res_ready", {31'd0, res_ready}, 32'd0);
    rd(8'h08, 32'h0000_0409, "full_status_busy");
    for (int i = 0; i < 4; i++) rd(8'h0C, i + 2, "full_result_pop");
    repeat (20) @(posedge clk);
    rd(8'h08, 32'h0000_000A, "full_status_done");
    rd(8'h10, 32'd12, "full_count");
    for (int i = 4; i < 12; i++) rd(8'h0C, i + 2, "full_result_rest");
    rd(8'h08, 32'h0000_0006, "full_status_empty");
    wr(8'h08, 32'h0000_0002);

    // Zero-length start with IRQ_EN: immediate DONE, irq until W1C.
    wr(8'h04, 32'd0);
    wr(8'h00, 32'h0000_0011);
    check("zero_irq_set", {31'd0, irq}, 32'd1);
    rd(8'h08, 32'h0000_0006, "zero_status");
    wr(8'h08, 32'h0000_0002);
    check("zero_irq_clear", {31'd0, irq}, 32'd0);
    rd(8'h08, 32'h0000_0004, "zero_status_clear");

    // Abort after 3 issues with the processor holding its results.
    proc_en = 1'b0; exp_mode = 2'd0;
    for (int i = 0; i < 3; i++) prod_q.push_back(32'h100 + i);
    wr(8'h04, 32'd10);
    wr(8'h00, 32'h0000_0001);
    repeat (10) @(posedge clk);
    wr(8'h04, 32'd5);
    rd(8'h04, 32'd10, "len_locked_busy");
    rd(8'h08, 32'h0000_0A05, "abort_status_run");
    wr(8'h00, 32'h0000_0002);
    rd(8'h08, 32'h0000_0A14, "abort_status");
    @(negedge clk);
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    proc_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_res_valid_seen", {31'd0, res_valid}, 32'd1);
    check("abort_res_ready", {31'd0, res_ready}, 32'd0);
    rd(8'h10, 32'd0, "abort_count");
    wr(8'h08, 32'h0000_0010);
    proc_en = 1'b0;
    proc_q.delete();

`ifdef DATAPROC_CTRL_TIMEOUT_EN
    // Silent processor: watchdog aborts 16 cycles after the last issue.
    exp_mode = 2'd0;
    prod_q.push_back(32'h200);
    prod_q.push_back(32'h201);
    wr(8'h04, 32'd2);
    wr(8'h00, 32'h0000_0001);
    repeat (8) @(posedge clk);
    rd(8'h08, 32'h0000_0205, "timeout_not_yet");
    repeat (30) @(posedge clk);
    rd(8'h08, 32'h0000_0234, "timeout_status");
    wr(8'h08, 32'h0000_0030);
    proc_q.delete();
`endif

    repeat (5) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
